seg_scan_driver: RTL

Time-multiplexed four-digit seven-segment driver placed downstream of the student-ID digit counter, replacing direct single-digit decoding when a four-digit common-anode display is fitted. It captures a 16-bit packed hex word into a shadow register on a load strobe, then scans the four digits round-robin at a parameterised rate. Each slot opens with an anti-ghosting blank interval, and optional leading-zero blanking applies. All display outputs are registered.

---
 rtl/seg_scan_driver_if.sv | 22 ++
 rtl/seg_scan_driver.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// Bus bundle for the four-digit seven-segment scan driver: digit/control inputs
// toward the driver and the registered display outputs back from it.
interface seg_scan_driver_if;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        load;
  logic        lzb;
  logic        en;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        slot_tick;

  modport master (
    output digits, dp, load, lzb, en,
    input  seg, an, slot_tick
  );

  modport slave (
    input  digits, dp, load, lzb, en,
    output seg, an, slot_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed four-digit common-anode seven-segment driver with a shadowed
// digit word, per-slot anti-ghosting blank window and leading-zero blanking.
module seg_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_driver_if.slave  bus
);

  localparam int             CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [31:0]    BLANK_LIM = 32'(BLANK_CYC);

  logic [15:0]   shadow_digits;
  logic [3:0]    shadow_dp;
  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic [7:0]    seg_q;
  logic [3:0]    an_q;
  logic          tick_q;

  logic          slot_end;
  logic          blank_win;
  logic [3:0]    cur_nib;
  logic          cur_dp;
  logic          cur_lz;
  logic [7:0]    cur_glyph;
  logic          zero3;
  logic          zero2;
  logic          zero1;
  logic          lz3;
  logic          lz2;
  logic          lz1;
  logic [7:0]    next_seg;
  logic [3:0]    next_an;
  logic          next_tick;

  // Active-low glyphs {dp,g,f,e,d,c,b,a}; the dp bit is replaced downstream.
  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      4'hF: g = 8'h8E;
      default: g = 8'hFF;
    endcase
    return g;
  endfunction

  assign slot_end  = (cnt == CNT_MAX);
  assign blank_win = (32'(cnt) < BLANK_LIM);

  // A digit is a leading zero only if it and every digit to its left are zero.
  assign zero3 = (shadow_digits[15:12] == 4'h0);
  assign zero2 = (shadow_digits[11:8]  == 4'h0);
  assign zero1 = (shadow_digits[7:4]   == 4'h0);
  assign lz3   = zero3;
  assign lz2   = zero3 & zero2;
  assign lz1   = zero3 & zero2 & zero1;

  always_comb begin
    cur_nib = shadow_digits[3:0];
    cur_dp  = shadow_dp[0];
    cur_lz  = 1'b0;
    case (slot)
      2'd0: begin
        cur_nib = shadow_digits[3:0];
        cur_dp  = shadow_dp[0];
        cur_lz  = 1'b0;
      end
      2'd1: begin
        cur_nib = shadow_digits[7:4];
        cur_dp  = shadow_dp[1];
        cur_lz  = lz1;
      end
      2'd2: begin
        cur_nib = shadow_digits[11:8];
        cur_dp  = shadow_dp[2];
        cur_lz  = lz2;
      end
      default: begin
        cur_nib = shadow_digits[15:12];
        cur_dp  = shadow_dp[3];
        cur_lz  = lz3;
      end
    endcase
  end

  assign cur_glyph = hex_glyph(cur_nib);

  // A blanked leading zero keeps its anode driven but shows nothing, dp included.
  always_comb begin
    next_seg  = 8'hFF;
    next_an   = 4'b1111;
    next_tick = 1'b0;
    if (bus.en) begin
      next_tick = slot_end;
      if (!blank_win) begin
        next_an = ~(4'b0001 << slot);
        if (!(bus.lzb && cur_lz)) begin
          next_seg = {~cur_dp, cur_glyph[6:0]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_digits <= 16'h0000;
      shadow_dp     <= 4'h0;
    end else if (bus.load) begin
      shadow_digits <= bus.digits;
      shadow_dp     <= bus.dp;
    end
  end

  // The prescaler and slot index freeze while disabled so the scan resumes in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      slot <= 2'd0;
    end else if (bus.en) begin
      if (slot_end) begin
        cnt  <= '0;
        slot <= slot + 2'd1;
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q  <= 8'hFF;
      an_q   <= 4'b1111;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= next_seg;
      an_q   <= next_an;
      tick_q <= next_tick;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.slot_tick = tick_q;

endmodule
